// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result bundle for the bit-serial adder/subtractor.
//   start, sub, A, B        : request and operands (driven by the master)
//   busy, done, Result,
//   Cout, Overflow          : status and registered results (driven by the slave)
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic             Cout;
    logic             Overflow;

    modport master (
        output start, sub, A, B,
        input  busy, done, Result, Cout, Overflow
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, Result, Cout, Overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, one bit per clock, LSB first.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : serial_addsub_if.slave
//            start/sub/A/B in; busy (SHIFT state), done (one-cycle pulse),
//            Result/Cout/Overflow (registered, held until the next completion)
// Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded with sub.
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_addsub_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             c_q, c_d;
    logic             msbc_q, msbc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             sum_bit, carry_bit;

    // Full adder on the current LSBs.
    assign sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            c_q      <= 1'b0;
            msbc_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            c_q      <= c_d;
            msbc_q   <= msbc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        c_d      = c_q;
        msbc_d   = msbc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B ^ {WIDTH{bus.sub}};
                    c_d     = bus.sub;
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                a_d = a_q >> 1;
                b_d = b_q >> 1;
                r_d = {sum_bit, r_q[WIDTH-1:1]};
                c_d = carry_bit;
                if (cnt_q == LAST) begin
                    // c_q is the carry into the MSB while the last bit is processed.
                    msbc_d  = c_q;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                // Outputs are registered here so the port never shows partial sums.
                result_d = r_q;
                cout_d   = c_q;
                ovf_d    = msbc_q ^ c_q;
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy     = (state_q == StShift);
    assign bus.done     = done_q;
    assign bus.Result   = result_q;
    assign bus.Cout     = cout_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub (WIDTH=8).
module tb_serial_addsub;
    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input int done_cyc);
        exp_t   e;
        longint ua, ub, sa, sb_v, raw, sr;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = ua - (a[W-1] ? (longint'(1) << W) : 0);
        sb_v = ub - (b[W-1] ? (longint'(1) << W) : 0);
        raw  = s ? ua - ub : ua + ub;
        sr   = s ? sa - sb_v : sa + sb_v;
        e.res  = raw[W-1:0];
        e.cout = s ? (ua >= ub) : (raw >= (longint'(1) << W));
        e.ovf  = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
        e.cyc  = done_cyc;
        return e;
    endfunction

    // Called at a negedge; start is sampled on the next edge, done seen W+1 edges later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input bit push);
        bus.A     = a;
        bus.B     = b;
        bus.sub   = s;
        bus.start = 1'b1;
        if (push) sb.push_back(model(a, b, s, cyc + W + 2));
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.sub   = 1'($urandom);
        repeat (W + 1) @(negedge clk);
    endtask

    // Monitor: pops on every done pulse, otherwise checks that outputs hold.
    logic [W-1:0] last_res;
    logic         last_cout, last_ovf;
    int           busy_run;

    always @(negedge clk) begin
        if (reset) begin
            last_res  = '0;
            last_cout = 1'b0;
            last_ovf  = 1'b0;
            busy_run  = 0;
        end else begin
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, W);
                busy_run = 0;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1, expected none (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("Result", bus.Result, e.res);
                    check("Cout", bus.Cout, e.cout);
                    check("Overflow", bus.Overflow, e.ovf);
                    last_res  = e.res;
                    last_cout = e.cout;
                    last_ovf  = e.ovf;
                end
            end else begin
                check("Result_hold", bus.Result, last_res);
                check("Cout_hold", bus.Cout, last_cout);
                check("Overflow_hold", bus.Overflow, last_ovf);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_Result"}, bus.Result, 0);
        check({tag, "_Cout"}, bus.Cout, 0);
        check({tag, "_Overflow"}, bus.Overflow, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_res  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        busy_run  = 0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b1;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors.
        issue(8'h25, 8'h17, 1'b0, 1'b1);
        issue(8'h7F, 8'h01, 1'b0, 1'b1);
        issue(8'hFF, 8'h01, 1'b0, 1'b1);
        issue(8'h10, 8'h20, 1'b1, 1'b1);
        issue(8'h80, 8'h01, 1'b1, 1'b1);

        // Start pulsed mid-SHIFT must be ignored.
        bus.A = 8'h01; bus.B = 8'h01; bus.sub = 1'b0; bus.start = 1'b1;
        sb.push_back(model(8'h01, 8'h01, 1'b0, cyc + W + 2));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.A = 8'hAA; bus.B = 8'h55; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (W) @(negedge clk);
        repeat (W + 2) @(negedge clk);

        // Reset in the 4th SHIFT cycle aborts the operation.
        bus.A = 8'h55; bus.B = 8'h0F; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(8'h03, 8'h04, 1'b0, 1'b1);

        // start held high: back-to-back every W+2 cycles.
        bus.A = 8'h01; bus.B = 8'h02; bus.sub = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model(8'h01, 8'h02, 1'b0, cyc + W + 2));
            repeat (W + 2) @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Random operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin an operation, sampled on clk rise.
REQ-005 The block SHALL have port sub  input  1  0 = A+B, 1 = A-B, sampled with start.
REQ-006 The block SHALL have port A  input  WIDTH  first operand, two's complement or unsigned.
REQ-007 The block SHALL have port B  input  WIDTH  second operand.
REQ-008 The block SHALL have port busy  output  1  high while bits are being processed.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-010 The block SHALL have port Result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-011 The block SHALL have port Cout  output  1  final carry out (for sub: 1 = no borrow).
REQ-012 The block SHALL have port Overflow  output  1  signed overflow flag.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 In IDLE with start=1, the block SHALL capture A, B XOR {WIDTH{sub}}, carry=sub, and bit counter=0, then enter SHIFT.
REQ-015 start SHALL be ignored in SHIFT and DONE; operand/sub changes after capture SHALL have no effect.
REQ-016 Each SHIFT cycle SHALL process one bit, LSB first: sum = a0^b0^c, carry = a0&b0 | a0&c | b0&c.
REQ-017 Each SHIFT cycle SHALL shift both operand registers right one bit and shift sum into the Result register at the MSB.
REQ-018 The block SHALL record the carry into the MSB position (before the last bit) for overflow.
REQ-019 After exactly WIDTH SHIFT cycles, the FSM SHALL enter DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-020 Latency: start sampled at edge N SHALL give done=1 in the cycle following edge N+WIDTH+1; busy SHALL be high for exactly WIDTH cycles (the SHIFT state).
REQ-021 In DONE, Cout SHALL equal the final carry and Overflow SHALL equal the MSB carry-in XOR Cout.
REQ-022 Result, Cout and Overflow SHALL update only in DONE and SHALL hold until the next accepted start completes.
REQ-023 Intermediate Result register contents SHALL NOT drive the Result port during SHIFT.
REQ-024 start held high continuously SHALL start a new operation on the first IDLE cycle after each DONE (back-to-back period WIDTH+2 cycles).

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, and SHALL set busy, done, Result, Cout, Overflow, counter and internal registers to 0, independent of clk.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after reset deasserts SHALL operate normally.

Verification (WIDTH=8)
REQ-027 A=0x25, B=0x17, sub=0, start one cycle -> busy 8 cycles, done one cycle, Result=0x3C, Cout=0, Overflow=0.
REQ-028 A=0x7F, B=0x01, sub=0 -> Result=0x80, Cout=0, Overflow=1; A=0xFF, B=0x01 -> Result=0x00, Cout=1, Overflow=0.
REQ-029 A=0x10, B=0x20, sub=1 -> Result=0xF0, Cout=0, Overflow=0; A=0x80, B=0x01, sub=1 -> Result=0x7F, Cout=1, Overflow=1.
REQ-030 Start op 0x01+0x01, then pulse start with A=0xAA, B=0x55 during SHIFT -> second start ignored, Result=0x02, only one done pulse.
REQ-031 Assert reset at SHIFT cycle 4 of any operation -> all outputs 0 asynchronously, no done pulse; a following 0x03+0x04 op yields Result=0x07.
REQ-032 Hold start=1 with 0x01+0x02 -> done pulses every 10 cycles, Result=0x03 each time.
